// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer and grants held for a full tenure.
// Optional tenure limit: define RR_ARB_TIMEOUT_EN to revoke grants held for MAX_TENURE cycles.
module rr_ring_arbiter #(
    parameter int N          = 3,
    parameter int MAX_TENURE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic [N-1:0]         ptr,
    output logic                 timeout
);

    localparam int          ID_W    = $clog2(N);
    localparam logic [N-1:0] PTR_RST = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Handshake: req is a level held by the owner for its whole tenure; gnt
    // (registered, one-hot) stays high until the owner's req is seen low.
    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;

    logic [N-1:0]    upper_req;
    logic [N-1:0]    pick_src;
    logic [N-1:0]    gnt_new;
    logic [ID_W-1:0] id_new;
    logic            revoke;

    // Requests at or above the pointer win first; otherwise wrap to the lowest set bit.
    always_comb begin
        upper_req = req & ~(ptr_q - PTR_RST);
        pick_src  = (|upper_req) ? upper_req : req;
        gnt_new   = pick_src & (~pick_src + PTR_RST);
        id_new    = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_new[i]) begin
                id_new = ID_W'(i);
            end
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_TENURE + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    assign revoke = (state_q == BUSY) && (|(req & gnt_q)) &&
                    (cnt_q == CNT_W'(MAX_TENURE - 1));

    // Counter sits at zero in IDLE so every tenure starts counting from zero.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = revoke;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (!revoke) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign revoke  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        gnt_id_d = gnt_id_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d    = gnt_new;
                    gnt_id_d = id_new;
                    ptr_d    = {gnt_new[N-2:0], gnt_new[N-1]};
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (!(|(req & gnt_q)) || revoke) begin
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                gnt_d    = '0;
                gnt_id_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            ptr_q    <= PTR_RST;
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            gnt_id_q <= gnt_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = gnt_id_q;
    assign ptr       = ptr_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            a_gnt_onehot0: assert ($onehot0(gnt_q));
            a_ptr_onehot:  assert ($onehot(ptr_q));
        end
    end

    if (N < 2 || MAX_TENURE < 1) begin : g_bad_params
        $error("rr_ring_arbiter: N must be >= 2 and MAX_TENURE >= 1");
    end
`endif

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Self-checking bench for rr_ring_arbiter: directed scenarios plus random requests
// compared every cycle against an index-based round-robin reference model.
module tb_rr_ring_arbiter;

    localparam int N     = 3;
    localparam int MAX_T = 4;
    localparam int IDW   = $clog2(N);
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic [N-1:0]   ptr;
    logic           timeout;

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 when idle), highest-priority index,
    // cycles the current grant has been high, and the expected timeout pulse.
    int m_owner;
    int m_prio;
    int m_tenure;
    bit m_timeout;

    int order [4] = '{1, 2, 4, 1};

    rr_ring_arbiter #(
        .N          (N),
        .MAX_TENURE (MAX_T)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .ptr       (ptr),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_prio    = 0;
        m_tenure  = 0;
        m_timeout = 1'b0;
    endtask

    function automatic bit bit_set(input logic [N-1:0] r, input int k);
        return ((r >> k) & N'(1)) != '0;
    endfunction

    task automatic model_edge(input logic [N-1:0] r);
        m_timeout = 1'b0;
        if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_prio + i) % N;
                if (bit_set(r, k)) begin
                    m_owner  = k;
                    m_prio   = (k + 1) % N;
                    m_tenure = 1;
                    break;
                end
            end
        end else if (!bit_set(r, m_owner)) begin
            m_owner = -1;
        end else if (TO_EN && m_tenure >= MAX_T) begin
            m_owner   = -1;
            m_timeout = 1'b1;
        end else begin
            m_tenure++;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [N-1:0]   e_gnt;
        logic [IDW-1:0] e_id;
        e_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e_id  = (m_owner >= 0) ? IDW'(m_owner) : '0;
        check({tag, "_gnt"},     8'(gnt),       8'(e_gnt));
        check({tag, "_valid"},   8'(gnt_valid), 8'(m_owner >= 0));
        check({tag, "_id"},      8'(gnt_id),    8'(e_id));
        check({tag, "_ptr"},     8'(ptr),       8'(N'(1) << m_prio));
        check({tag, "_timeout"}, 8'(timeout),   8'(m_timeout));
    endtask

    task automatic cycle(input logic [N-1:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [N-1:0] r;

        // Reset values
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with no requests: pointer must not move
        for (int i = 0; i < 10; i++) cycle(3'b000, "idle");

        // All requesting: strict rotation, one idle cycle between tenures
        for (int t = 0; t < 4; t++) begin
            cycle(3'b111, "rot_grant");
            check("rot_order", 8'(gnt), 8'(order[t]));
            cycle(3'b111, "rot_hold");
            cycle(3'b111 & ~gnt, "rot_release");
            check("rot_gap", 8'(gnt), 8'h00);
        end

        // ptr=010, req=101: upward search reaches bit 2 before wrapping
        cycle(3'b101, "search");
        check("search_gnt", 8'(gnt), 8'h04);
        check("search_ptr", 8'(ptr), 8'h01);
        cycle(3'b000, "search_rel");

        // Owner holds while others toggle, then drops
        cycle(3'b010, "hold_grant");
        for (int i = 0; i < 2; i++) begin
            r = N'($urandom_range(0, 7)) | 3'b010;
            cycle(r, "hold_toggle");
            check("hold_same", 8'(gnt), 8'h02);
        end
        r = N'($urandom_range(0, 7)) & 3'b101;
        cycle(r, "hold_drop");
        check("hold_dropped", 8'(gnt), 8'h00);

        // Asynchronous reset mid-tenure with gnt=010
        cycle(3'b010, "arst_grant");
        cycle(3'b010, "arst_hold");
        check("arst_pre", 8'(gnt), 8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gnt", 8'(gnt), 8'h00);
        check("arst_ptr", 8'(ptr), 8'h01);
        model_reset();
        check_outputs("arst");
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester held for a long time (revoked only with the tenure limit)
        for (int i = 0; i < 110; i++) cycle(3'b001, "long_hold");

        // Random requests against the model
        for (int i = 0; i < 400; i++) begin
            r = N'($urandom_range(0, 7));
            cycle(r, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
